// File: rtl/alu_mul_sequencer_if.sv
// Request/response and shared-ALU signals between the execute stage and the MUL/MLA sequencer.
// The master side is the execute stage together with the shared ALU; the slave side is the sequencer.
interface alu_mul_sequencer_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] acc_in;
  logic        accumulate;
  logic        set_flags;
  logic [31:0] alu_out;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        n_flag;
  logic        z_flag;
  logic        flags_we;

  modport master (
    output start, op_a, op_b, acc_in, accumulate, set_flags, alu_out,
    input  alu_own, alu_a, alu_b, alu_op, alu_cin, busy, done, result,
           n_flag, z_flag, flags_we
  );

  modport slave (
    input  start, op_a, op_b, acc_in, accumulate, set_flags, alu_out,
    output alu_own, alu_a, alu_b, alu_op, alu_cin, busy, done, result,
           n_flag, z_flag, flags_we
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// MUL/MLA sequencer: shift-and-add multiply (low 32 bits) that borrows the shared ALU for one ADD per multiplier bit.
//   state | meaning
//   IDLE  | waiting for start; ALU released
//   RUN   | one ADD per cycle; acc <= alu_out, mcand <<= 1, mplier >>= 1
//   DONE  | one-cycle done pulse, result and flags valid
module alu_mul_sequencer (
  input logic              clk,
  input logic              reset,
  alu_mul_sequencer_if.slave bus
);
  localparam logic [3:0] ADD_OP = 4'b0100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [31:0] result_q;
  logic        sf_q;
  logic        own_q;
  logic        last_iter;

  // Stop once no set multiplier bits remain above the one consumed this cycle.
  assign last_iter = (mplier_q[31:1] == 31'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sf_q     <= 1'b0;
      own_q    <= 1'b0;
    end else begin
      own_q <= (state_d == RUN);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q  <= bus.op_a;
            mplier_q <= bus.op_b;
            acc_q    <= bus.accumulate ? bus.acc_in : 32'd0;
            sf_q     <= bus.set_flags;
          end
        end
        RUN: begin
          acc_q    <= bus.alu_out;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (last_iter) result_q <= bus.alu_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_own  = own_q;
  assign bus.alu_a    = own_q ? acc_q : 32'd0;
  assign bus.alu_b    = (own_q && mplier_q[0]) ? mcand_q : 32'd0;
  assign bus.alu_op   = ADD_OP;
  assign bus.alu_cin  = 1'b0;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.flags_we = (state_q == DONE) && sf_q;
  assign bus.result   = result_q;
  assign bus.n_flag   = result_q[31];
  assign bus.z_flag   = (result_q == 32'd0);
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a combinational ADD model standing in for the shared ALU.
module tb_alu_mul_sequencer;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  alu_mul_sequencer_if bus ();

  alu_mul_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.alu_out = (bus.alu_op == 4'b0100) ?
                       (bus.alu_a + bus.alu_b + {31'd0, bus.alu_cin}) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                       input logic accum, input logic sf);
    @(negedge clk);
    bus.op_a       = a;
    bus.op_b       = b;
    bus.acc_in     = acc;
    bus.accumulate = accum;
    bus.set_flags  = sf;
    bus.start      = 1'b1;
    @(posedge clk);
    #1 bus.start   = 1'b0;
  endtask

  // Counts cycles after acceptance until done; records ALU ownership and bus hygiene.
  task automatic wait_done(output int cyc, output int own, output bit opok, output bit busyok);
    cyc    = -1;
    own    = 0;
    opok   = 1'b1;
    busyok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.alu_own) begin
        own++;
        if (bus.alu_op !== 4'b0100) opok = 1'b0;
      end else if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
        opok = 1'b0;
      end
      if (bus.busy !== 1'b1) busyok = 1'b0;
      if (bus.done === 1'b1) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] acc, input logic accum, input logic sf,
                        input logic [31:0] exp_res, input logic exp_n, input logic exp_z,
                        input int n);
    int  cyc, own;
    bit  opok, busyok;
    issue(a, b, acc, accum, sf);
    wait_done(cyc, own, opok, busyok);
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_n"}, {31'd0, bus.n_flag}, {31'd0, exp_n});
    chk({tag, "_z"}, {31'd0, bus.z_flag}, {31'd0, exp_z});
    chk({tag, "_we"}, {31'd0, bus.flags_we}, {31'd0, sf});
    chk({tag, "_done_cyc"}, cyc, n + 1);
    chk({tag, "_own_cycles"}, own, n);
    chk({tag, "_alu_bus"}, {31'd0, opok}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busyok}, 32'd1);
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    int  cyc, own;
    bit  opok, busyok, saw_done;
    tests = 0;
    fails = 0;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.acc_in = '0;
    bus.accumulate = 1'b0; bus.set_flags = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_we", {31'd0, bus.flags_we}, 32'd0);
    chk("rst_own", {31'd0, bus.alu_own}, 32'd0);
    chk("rst_cin", {31'd0, bus.alu_cin}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_op", {28'd0, bus.alu_op}, 32'd4);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_nz", {30'd0, bus.n_flag, bus.z_flag}, 32'd1);
    reset = 1'b0;

    run_op("mul7x6", 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 32'd42, 1'b0, 1'b0, 3);
    run_op("mla3x5p10", 32'd3, 32'd5, 32'd10, 1'b1, 1'b0, 32'd25, 1'b0, 1'b0, 3);
    run_op("neg", 32'h9C00_0038, 32'd1, 32'd0, 1'b0, 1'b1, 32'h9C00_0038, 1'b1, 1'b0, 1);
    run_op("wrap0", 32'h8000_0000, 32'd2, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 2);
    run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 32);
    run_op("zero_mplier", 32'hAAAA_5555, 32'd0, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1);

    // start pulses during RUN and DONE must be ignored
    issue(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd100; bus.op_b = 32'd100;
    @(negedge clk);
    bus.start = 1'b0;
    saw_done = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
    end
    chk("busy_first_done", {31'd0, saw_done}, 32'd1);
    chk("busy_first_result", bus.result, 32'd15);
    bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_done_ignored", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("still_idle", {31'd0, bus.busy}, 32'd0);
    chk("result_held", bus.result, 32'd15);

    // start held high: re-accepted in the IDLE cycle after done
    bus.op_a = 32'd2; bus.op_b = 32'd3; bus.accumulate = 1'b0; bus.set_flags = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    wait_done(cyc, own, opok, busyok);
    chk("hold_done_cyc", cyc, 3);
    chk("hold_result1", bus.result, 32'd6);
    @(negedge clk);
    chk("hold_idle_gap", {31'd0, bus.busy}, 32'd0);
    bus.op_a = 32'd4; bus.op_b = 32'd5;
    @(negedge clk);
    chk("hold_reaccept", {30'd0, bus.busy, bus.alu_own}, 32'd3);
    bus.start = 1'b0;
    wait_done(cyc, own, opok, busyok);
    chk("hold_result2", bus.result, 32'd20);
    @(negedge clk);

    // reset in the middle of a 32-iteration operation
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_own", {31'd0, bus.alu_own}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_alu_a", bus.alu_a, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 35; c++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_op("after_abort", 32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
